// File: rtl/tone_detect_if.sv
// tone_detect_if: tone detector signal bundle
// piezo    : raw square-wave tone input (driven by master)
// note     : current note code 0=NONE 1=G6 2=C7 3=E7 4=G7 (driven by slave)
// note_vld : one-cycle pulse on change to a nonzero note (driven by slave)
// seq_done : one-cycle pulse when the charge fanfare completes (driven by slave)
interface tone_detect_if;
  logic       piezo;
  logic [2:0] note;
  logic       note_vld;
  logic       seq_done;
  modport master (output piezo, input note, note_vld, seq_done);
  modport slave  (input piezo, output note, note_vld, seq_done);
endinterface

// File: rtl/tone_detect.sv
// tone_detect: piezo period classifier with note debounce and charge fanfare recognizer
// clk      : 50 MHz system clock
// rst_n    : asynchronous active-low reset
// bus      : tone_detect_if.slave (piezo in; note, note_vld, seq_done out)
// MATCH_CNT: consecutive in-window periods needed to declare a note
// TONE_SEQ_DET_EN: when defined, builds the fanfare FSM; otherwise seq_done is 0
module tone_detect #(
  parameter int MATCH_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tone_detect_if.slave  bus
);
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam logic [2:0] G6 = 3'd1, C7 = 3'd2, E7 = 3'd3, G7 = 3'd4;
  logic [2:0]    sync;
  logic [15:0]   cnt;
  logic          first;
  logic [2:0]    cand, note, cls;
  logic [MW-1:0] mcnt, mcnt_nxt;
  logic          note_vld;
  logic          rise, sat;
  assign rise = sync[1] & ~sync[2];
  // a saturated period counter doubles as the silence indicator
  assign sat  = &cnt;
  always_comb begin
    cls = (cnt >= 16'd30931 && cnt <= 16'd32845) ? G6 :
          (cnt >= 16'd23172 && cnt <= 16'd24606) ? C7 :
          (cnt >= 16'd18392 && cnt <= 16'd19530) ? E7 :
          (cnt >= 16'd15466 && cnt <= 16'd16422) ? G7 : 3'd0;
    mcnt_nxt = (cls != cand) ? MW'(1) :
               (mcnt == MW'(MATCH_CNT)) ? mcnt : mcnt + MW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      cnt      <= '0;
      first    <= 1'b1;
      cand     <= '0;
      mcnt     <= '0;
      note     <= '0;
      note_vld <= 1'b0;
    end else begin
      sync     <= {sync[1:0], bus.piezo};
      note_vld <= 1'b0;
      cnt      <= rise ? 16'd1 : sat ? cnt : cnt + 16'd1;
      // silence re-arms the first-edge flag; an edge arriving with it starts a new measurement
      if (sat || (rise && first)) begin
        cand  <= '0;
        mcnt  <= '0;
        first <= ~rise;
        if (sat) note <= '0;
      end else if (rise) begin
        if (cls == 3'd0) begin
          cand <= '0;
          mcnt <= '0;
        end else begin
          cand <= cls;
          mcnt <= mcnt_nxt;
          if (mcnt_nxt == MW'(MATCH_CNT) && cls != note) begin
            note     <= cls;
            note_vld <= 1'b1;
          end
        end
      end
    end
  end
  assign bus.note     = note;
  assign bus.note_vld = note_vld;
`ifdef TONE_SEQ_DET_EN
  typedef enum logic [2:0] {IDLE, S_G6, S_C7, S_E7, S_G7, S_E7B} state_t;
  state_t     state, state_nxt;
  logic       done, done_nxt;
  logic [2:0] want;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    want = (state == IDLE) ? G6 : (state == S_G6) ? C7 : (state == S_C7) ? E7 :
           (state == S_E7) ? G7 : (state == S_G7) ? E7 : G7;
    if (sat) state_nxt = IDLE;
    else if (note_vld) begin
      if (note != want) state_nxt = (note == G6) ? S_G6 : IDLE;
      else if (state == S_E7B) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else state_nxt = state_t'(state + 3'd1);
    end
  end
  assign bus.seq_done = done;
`else
  assign bus.seq_done = 1'b0;
`endif
endmodule

// File: tb/tb_tone_detect.sv
// tb_tone_detect: scoreboard bench for tone_detect (MATCH_CNT=2)
module tb_tone_detect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  tone_detect_if bus();
  tone_detect #(.MATCH_CNT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef TONE_SEQ_DET_EN
  localparam int EXP_SD = 1;
`else
  localparam int EXP_SD = 0;
`endif
  int nvec = 0;
  int nerr = 0;
  int nv_cnt = 0;
  int sd_cnt = 0;
  int exp_q[$];
  logic prev_nv = 1'b0;
  logic [2:0] prev_note = '0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic tone(input int p, input int n);
    repeat (n) begin
      bus.piezo = 1'b1;
      cyc(p / 2);
      bus.piezo = 1'b0;
      cyc(p - p / 2);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.note_vld) begin
        nv_cnt++;
        check("nv_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("nv_code", bus.note, exp_q.pop_front());
        check("nv_single_cycle", prev_nv, 0);
      end
      if (bus.seq_done) begin
        sd_cnt++;
        check("sd_after_nv_g7", {prev_nv, prev_note}, 4'b1100);
      end
    end
    prev_nv   <= bus.note_vld;
    prev_note <= bus.note;
  end
  initial begin
    bus.piezo = 1'b0;
    cyc(3);
    check("rst_note", bus.note, 0);
    check("rst_nv", bus.note_vld, 0);
    check("rst_sd", bus.seq_done, 0);
    rst_n = 1'b1;
    cyc(5);
    tone(20000, 3);
    cyc(10);
    check("oow_note", bus.note, 0);
    check("oow_nv_cnt", nv_cnt, 0);
    exp_q = {1, 2, 3, 4, 3, 4};
    tone(31888, 3); tone(23889, 2); tone(18961, 2);
    tone(15944, 2); tone(18961, 2); tone(15944, 4);
    cyc(10);
    check("seq_nv_cnt", nv_cnt, 6);
    check("seq_q_left", exp_q.size(), 0);
    check("seq_sd_cnt", sd_cnt, EXP_SD);
    check("seq_note_held", bus.note, 4);
    cyc(70000);
    check("silence_note", bus.note, 0);
    check("silence_nv_cnt", nv_cnt, 6);
    nv_cnt = 0;
    sd_cnt = 0;
    exp_q = {1, 2, 3, 4, 3, 4};
    tone(31888, 3); tone(23889, 2); tone(18961, 3);
    check("gap_pre_note", bus.note, 3);
    cyc(70000);
    check("gap_note", bus.note, 0);
    check("gap_nv_cnt", nv_cnt, 3);
    tone(16422, 3); tone(18392, 2); tone(15944, 3);
    cyc(10);
    check("gap_post_nv_cnt", nv_cnt, 6);
    check("gap_q_left", exp_q.size(), 0);
    check("gap_sd_cnt", sd_cnt, 0);
    nv_cnt = 0;
    exp_q = {1, 2, 3, 4, 3};
    tone(31888, 3); tone(23889, 2); tone(18961, 2);
    tone(15944, 2); tone(18961, 2); tone(15944, 2);
    check("mid_note_pre_rst", bus.note, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_note", bus.note, 0);
    check("mid_rst_nv", bus.note_vld, 0);
    check("mid_rst_sd", bus.seq_done, 0);
    check("mid_rst_nv_cnt", nv_cnt, 5);
    cyc(5);
    rst_n = 1'b1;
    exp_q.push_back(1);
    tone(30931, 3);
    cyc(10);
    check("post_rst_nv_cnt", nv_cnt, 6);
    check("post_rst_note", bus.note, 1);
    check("post_rst_sd_cnt", sd_cnt, 0);
    check("post_rst_q_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tone_detect.md
TONE_DETECT -- requirements
Module: tone_detect

Interface
REQ-001 Parameter: MATCH_CNT, default 4, number of consecutive in-window periods required to declare a note.
REQ-002 Port: clk  input  1  system clock, 50 MHz.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: piezo  input  1  asynchronous square-wave tone input.
REQ-005 Port: note  output  3  current note code: 0=NONE, 1=G6, 2=C7, 3=E7, 4=G7; 5-7 never driven.
REQ-006 Port: note_vld  output  1  one-cycle pulse when note changes to a nonzero code.
REQ-007 Port: seq_done  output  1  one-cycle pulse when the full charge fanfare has been recognized.

Function
REQ-008 The block SHALL pass piezo through a 2-flop synchronizer, then one further flop for rising-edge detection.
REQ-009 The block SHALL measure period P as the number of clk cycles between successive detected rising edges.
REQ-010 The period counter SHALL be 16 bits and saturate at 65535.
REQ-011 The first rising edge after reset or after silence SHALL only start measurement and SHALL NOT be classified.
REQ-012 The block SHALL classify P (inclusive windows): G6 30931-32845, C7 23172-24606, E7 18392-19530, G7 15466-16422; otherwise out-of-window.
REQ-013 If a classified P equals the held candidate, the match count SHALL increment, saturating at MATCH_CNT; otherwise the candidate SHALL be replaced and the count SHALL be set to 1.
REQ-014 An out-of-window P SHALL clear the candidate and the match count, and SHALL leave note unchanged.
REQ-015 When the match count reaches MATCH_CNT and the candidate differs from note, note SHALL update and note_vld SHALL pulse in the cycle after the completing edge is detected.
REQ-016 A held note SHALL NOT re-pulse note_vld; repeated identical periods keep note stable.
REQ-017 Silence SHALL be declared when the period counter saturates: note SHALL go to 0, the candidate and match count SHALL clear, note_vld SHALL NOT pulse, and the first-edge flag SHALL be set.
REQ-018 The sequence FSM SHALL have states IDLE, S_G6, S_C7, S_E7, S_G7, S_E7B and SHALL advance only on note_vld.
REQ-019 Expected order from IDLE: G6 -> S_G6, C7 -> S_C7, E7 -> S_E7, G7 -> S_G7, E7 -> S_E7B, G7 -> seq_done.
REQ-020 On the final G7, seq_done SHALL pulse in the cycle after note_vld, and the FSM SHALL return to IDLE.
REQ-021 On a mismatching note, the FSM SHALL go to S_G6 if the note is G6, and to IDLE otherwise.
REQ-022 On silence, the FSM SHALL go to IDLE.
REQ-023 If silence and an edge coincide in the same cycle, the edge SHALL be treated as a first edge.

Reset
REQ-024 While rst_n is low, the block SHALL drive note=0, note_vld=0, seq_done=0.
REQ-025 While rst_n is low, the FSM SHALL be in IDLE, the counters and candidate SHALL be clear, the synchronizer flops SHALL be 0, and the first-edge flag SHALL be set.
REQ-026 Reset asserted mid-note or mid-sequence SHALL abort immediately, with no pulse emitted.

Configuration
REQ-027 Macro TONE_SEQ_DET_EN SHALL control compilation of the sequence FSM (REQ-018..REQ-023).
REQ-028 When TONE_SEQ_DET_EN is defined, the FSM SHALL be present and seq_done SHALL behave per REQ-020.
REQ-029 When TONE_SEQ_DET_EN is undefined, the FSM SHALL be absent, seq_done SHALL be tied to 0, and note decoding SHALL be unchanged.

Verification
REQ-030 Scenario: square wave, period 31888, for 6 periods -> note=1, one note_vld pulse after the 5th edge (first edge plus 4 matches), no further pulses.
REQ-031 Scenario: period 20000 (out-of-window) for 10 periods -> note stays 0, note_vld never pulses.
REQ-032 Scenario: periods 31888, 23889, 18961, 15944, 18961, 15944, 6 periods each, contiguous -> note_vld ×6 with codes 1,2,3,4,3,4; seq_done is exactly one pulse, one cycle after the last note_vld (macro defined).
REQ-033 Scenario: same as REQ-032 with the input held low for 70000 cycles between E7 and G7 -> note=0 during the gap, FSM to IDLE, no seq_done.
REQ-034 Scenario: rst_n pulsed low during the G7 note of REQ-032 -> outputs are 0 immediately, no seq_done; the next 31888-period tone is detected normally.
REQ-035 Scenario: REQ-032 with TONE_SEQ_DET_EN undefined -> identical note and note_vld behaviour, seq_done constant 0.
